// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master and its clock generator.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, XFER, HOLD} spi_state_t;

   // A single chip select still needs a one-bit index port.
   function automatic int cs_width(input int num_cs);
      return (num_cs > 1) ? $clog2(num_cs) : 1;
   endfunction

endpackage

// File: rtl/spi_master_clk_gen.sv
// SCK generator: half-period down-counter plus edge counter, with
// per-edge strobes for the master's shift logic.
module spi_clk_gen #(
   parameter int DATA_WIDTH  = 8,
   parameter int DATA_PERIOD = 100
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic run,
   input  logic cpol,
   output logic data_clk_out,
   output logic lead_stb,
   output logic trail_stb,
   output logic last_stb
);

   localparam int HALF = DATA_PERIOD / 2;
   localparam int CW   = $clog2(DATA_PERIOD) + 1;
   localparam int EW   = $clog2(2 * DATA_WIDTH + 1);

   logic [CW-1:0] half_cnt;
   logic [EW-1:0] edge_cnt;
   logic          edge_stb;

   // edge_cnt holds edges already produced, so an even count means the
   // upcoming edge is a leading (odd-numbered) one.
   assign edge_stb  = run && (half_cnt == '0);
   assign lead_stb  = edge_stb && !edge_cnt[0];
   assign trail_stb = edge_stb &&  edge_cnt[0];
   assign last_stb  = edge_stb && (edge_cnt == EW'(2 * DATA_WIDTH - 1));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         half_cnt     <= '0;
         edge_cnt     <= '0;
         data_clk_out <= 1'b0;
      end else if (!run) begin
         half_cnt     <= CW'(HALF - 1);
         edge_cnt     <= '0;
         data_clk_out <= cpol;
      end else if (edge_stb) begin
         half_cnt     <= CW'(HALF - 1);
         edge_cnt     <= edge_cnt + EW'(1);
         data_clk_out <= lead_stb ? ~cpol : cpol;
      end else begin
         half_cnt     <= half_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master: all four CPOL/CPHA modes, NUM_CS active-low
// selects, ready/valid request handshake.
//
// state | meaning
// IDLE  | ready for a request; SCK tracks cpol_in
// XFER  | 2*DATA_WIDTH SCK edges, shifting copi out and cipo in
// HOLD  | one half period with select held, then complete
module spi_master
   import spi_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int DATA_PERIOD = 100,
   parameter  int NUM_CS      = 1,
   localparam int CSW         = cs_width(NUM_CS)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CSW-1:0]        cs_sel_in,
   input  logic                  cpol_in,
   input  logic                  cpha_in,
   input  logic                  trigger_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid_out,
   output logic                  copi_out,
   input  logic                  cipo_in,
   output logic                  data_clk_out,
   output logic [NUM_CS-1:0]     sel_out
);

   localparam int HALF = DATA_PERIOD / 2;
   localparam int HW   = $clog2(DATA_PERIOD);

   spi_state_t            state, state_nxt;
   logic                  accept, hold_done;
   logic                  cpol_q, cpha_q, clk_cpol;
   logic                  lead_stb, trail_stb, last_stb;
   logic                  sample_stb, shift_stb;
   logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
   logic [HW-1:0]         hold_cnt;
   logic [NUM_CS-1:0]     sel_dec;

   assign ready_out = (state == IDLE);
   assign clk_cpol  = (state == IDLE) ? cpol_in : cpol_q;

   spi_clk_gen #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DATA_PERIOD (DATA_PERIOD)
   ) u_clk_gen (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .run          (state == XFER),
      .cpol         (clk_cpol),
      .data_clk_out (data_clk_out),
      .lead_stb     (lead_stb),
      .trail_stb    (trail_stb),
      .last_stb     (last_stb)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      hold_done = 1'b0;
      unique case (state)
         IDLE: if (trigger_in) begin
            accept    = 1'b1;
            state_nxt = XFER;
         end
         XFER: if (last_stb) state_nxt = HOLD;
         HOLD: if (hold_cnt == '0) begin
            hold_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An out-of-range index matches no line, so the transfer runs unselected.
   always_comb begin
      sel_dec = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (cs_sel_in == CSW'(i)) sel_dec[i] = 1'b0;
   end

   assign sample_stb = cpha_q ? trail_stb : lead_stb;
   assign shift_stb  = cpha_q ? lead_stb  : (trail_stb && !last_stb);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         copi_out       <= 1'b0;
         sel_out        <= '1;
         data_out       <= '0;
         data_valid_out <= 1'b0;
         tx_sh          <= '0;
         rx_sh          <= '0;
         cpol_q         <= 1'b0;
         cpha_q         <= 1'b0;
         hold_cnt       <= '0;
      end else begin
         data_valid_out <= 1'b0;
         if (accept) begin
            // cpha=0 presents the MSB now, so the register keeps only the rest.
            tx_sh    <= cpha_in ? data_in : {data_in[DATA_WIDTH-2:0], 1'b0};
            copi_out <= cpha_in ? 1'b0 : data_in[DATA_WIDTH-1];
            rx_sh    <= '0;
            cpol_q   <= cpol_in;
            cpha_q   <= cpha_in;
            sel_out  <= sel_dec;
         end
         if (state == XFER) begin
            if (sample_stb) rx_sh <= {rx_sh[DATA_WIDTH-2:0], cipo_in};
            if (shift_stb) begin
               copi_out <= tx_sh[DATA_WIDTH-1];
               tx_sh    <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
            end
            if (last_stb) hold_cnt <= HW'(HALF - 1);
         end
         if (state == HOLD && !hold_done) hold_cnt <= hold_cnt - HW'(1);
         if (hold_done) begin
            sel_out        <= '1;
            copi_out       <= 1'b0;
            data_out       <= rx_sh;
            data_valid_out <= 1'b1;
         end
      end
   end

endmodule
